robo_sequenciador: RTL and testbench

//  Sequences the wall-following decision FSM against the physical robot. Conditions raw head/left sensors,

---
 rtl/robo_pkg.sv | 28 ++
 rtl/robo_debounce.sv | 53 +++++
 rtl/robo_sequenciador.sv | 182 ++++++++++++++++++
 tb/tb_robo_sequenciador.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/robo_pkg.sv
// Shared encodings for the robot sequencer: controller states, motor command codes and fault codes.
package robo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_STEP,
        ST_CAPTURE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE,
        ST_FAULT
    } state_t;

    localparam logic [1:0] MOT_NONE    = 2'b00;
    localparam logic [1:0] MOT_AVANCAR = 2'b01;
    localparam logic [1:0] MOT_GIRAR   = 2'b10;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_TIMEOUT = 2'b01;
    localparam logic [1:0] FLT_STUCK   = 2'b10;
    localparam logic [1:0] FLT_ILLEGAL = 2'b11;

    function automatic logic is_busy(input state_t s);
        return !(s == ST_IDLE || s == ST_DONE || s == ST_FAULT);
    endfunction

endpackage

// File: rtl/robo_debounce.sv
// Two-flop synchronizer per sensor bit followed by a shared stability counter.
// stable rises in the DEB_CYC-th cycle that the synchronized pair has held its value.
module robo_debounce
    import robo_pkg::*;
#(
    parameter int DEB_CYC = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       restart,
    input  logic [1:0] raw,
    output logic       stable,
    output logic [1:0] pair
);

    localparam int CNT_W = $clog2(DEB_CYC) + 1;

    logic [1:0]       sync_bits;
    logic [1:0]       diff_bits;
    logic [CNT_W-1:0] cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clock) begin
                if (reset) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= raw[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync_bits[gi] = sync_reg;
            // A difference between the stages means a new value lands in sync_reg next cycle.
            assign diff_bits[gi] = meta_reg ^ sync_reg;
        end
    endgenerate

    assign stable = (cnt_reg == CNT_W'(DEB_CYC - 1));
    assign pair   = sync_bits;

    always_ff @(posedge clock) begin
        if (reset || restart || (|diff_bits)) begin
            cnt_reg <= '0;
        end else if (!stable) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/robo_sequenciador.sv
// Mission sequencer: debounces sensors, steps the decision FSM once per move, hands the command
// to the motor driver over valid/ready and supervises completion, counting moves and raising faults.
module robo_sequenciador
    import robo_pkg::*;
#(
    parameter int DEB_CYC    = 8,
    parameter int TIMEOUT    = 1024,
    parameter int MAX_GIROS  = 4,
    parameter int STEP_W     = 16,
    parameter int MAX_PASSOS = 1000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              head_raw,
    input  logic              left_raw,
    output logic              fsm_head,
    output logic              fsm_left,
    output logic              fsm_step,
    input  logic              fsm_avancar,
    input  logic              fsm_girar,
    output logic [1:0]        mot_cmd,
    output logic              mot_valid,
    input  logic              mot_ready,
    input  logic              mot_done,
    output logic              busy,
    output logic              concluido,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic [STEP_W-1:0] passos
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(MAX_GIROS + 1);

    state_t            state_reg, state_next;
    logic [1:0]        cmd_reg, cmd_next;
    logic [1:0]        code_reg, code_next;
    logic              head_reg, head_next;
    logic              left_reg, left_next;
    logic              stop_reg, stop_next;
    logic [STEP_W-1:0] passos_reg, passos_next, passos_inc;
    logic [GW-1:0]     giros_reg, giros_next, giros_inc;
    logic [TW-1:0]     timer_reg, timer_next;
    logic              restart;
    logic              stable;
    logic [1:0]        pair;

    robo_debounce #(.DEB_CYC(DEB_CYC)) u_debounce (
        .clock   (clock),
        .reset   (reset),
        .restart (restart),
        .raw     ({head_raw, left_raw}),
        .stable  (stable),
        .pair    (pair)
    );

    // Saturating increments so the counters can never wrap past their limits.
    assign passos_inc = (passos_reg >= STEP_W'(MAX_PASSOS)) ? passos_reg : passos_reg + STEP_W'(1);
    assign giros_inc  = (giros_reg >= GW'(MAX_GIROS)) ? giros_reg : giros_reg + GW'(1);

    always_comb begin
        state_next  = state_reg;
        cmd_next    = cmd_reg;
        code_next   = code_reg;
        head_next   = head_reg;
        left_next   = left_reg;
        stop_next   = stop_reg;
        passos_next = passos_reg;
        giros_next  = giros_reg;
        timer_next  = timer_reg;
        restart     = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_FAULT: begin
                // From IDLE a simultaneous stop cancels the start; from DONE/FAULT start still clears.
                if (start && (!stop || state_reg != ST_IDLE)) begin
                    passos_next = '0;
                    giros_next  = '0;
                    code_next   = FLT_NONE;
                    cmd_next    = MOT_NONE;
                    stop_next   = 1'b0;
                    state_next  = stop ? ST_IDLE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (stable) begin
                    head_next  = pair[1];
                    left_next  = pair[0];
                    state_next = ST_STEP;
                end
            end
            ST_STEP: begin
                state_next = stop ? ST_IDLE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (fsm_avancar != fsm_girar) begin
                    cmd_next   = fsm_avancar ? MOT_AVANCAR : MOT_GIRAR;
                    state_next = ST_ISSUE;
                end else begin
                    code_next  = FLT_ILLEGAL;
                    state_next = ST_FAULT;
                end
            end
            ST_ISSUE: begin
                if (stop) stop_next = 1'b1;
                if (mot_ready) begin
                    timer_next = '0;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (stop) stop_next = 1'b1;
                timer_next = timer_reg + TW'(1);
                if (mot_done) begin
                    if (cmd_reg == MOT_AVANCAR) begin
                        passos_next = passos_inc;
                        giros_next  = '0;
                    end else begin
                        giros_next = giros_inc;
                    end
                    if (cmd_reg == MOT_AVANCAR && passos_inc == STEP_W'(MAX_PASSOS)) begin
                        state_next = ST_DONE;
                    end else if (cmd_reg == MOT_GIRAR && giros_inc == GW'(MAX_GIROS)) begin
                        code_next  = FLT_STUCK;
                        state_next = ST_FAULT;
                    end else if (stop_reg || stop) begin
                        stop_next  = 1'b0;
                        state_next = ST_IDLE;
                    end else begin
                        restart    = 1'b1;
                        state_next = ST_SETTLE;
                    end
                end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                    code_next  = FLT_TIMEOUT;
                    state_next = ST_FAULT;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            cmd_reg    <= MOT_NONE;
            code_reg   <= FLT_NONE;
            head_reg   <= 1'b0;
            left_reg   <= 1'b0;
            stop_reg   <= 1'b0;
            passos_reg <= '0;
            giros_reg  <= '0;
            timer_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            cmd_reg    <= cmd_next;
            code_reg   <= code_next;
            head_reg   <= head_next;
            left_reg   <= left_next;
            stop_reg   <= stop_next;
            passos_reg <= passos_next;
            giros_reg  <= giros_next;
            timer_reg  <= timer_next;
        end
    end

    assign fsm_head   = head_reg;
    assign fsm_left   = left_reg;
    assign fsm_step   = (state_reg == ST_STEP);
    assign mot_valid  = (state_reg == ST_ISSUE);
    assign mot_cmd    = (state_reg == ST_ISSUE || state_reg == ST_WAIT) ? cmd_reg : MOT_NONE;
    assign busy       = is_busy(state_reg);
    assign concluido  = (state_reg == ST_DONE);
    assign fault      = (state_reg == ST_FAULT);
    assign fault_code = code_reg;
    assign passos     = passos_reg;

endmodule

// File: tb/tb_robo_sequenciador.sv
// Directed bench for robo_sequenciador: the bench plays decision FSM and motor driver,
// with hand-computed expectations for each scenario.
module tb_robo_sequenciador;

    logic        clock;
    logic        reset;
    logic        start;
    logic        stop;
    logic        head_raw;
    logic        left_raw;
    logic        fsm_head;
    logic        fsm_left;
    logic        fsm_step;
    logic        fsm_avancar;
    logic        fsm_girar;
    logic [1:0]  mot_cmd;
    logic        mot_valid;
    logic        mot_ready;
    logic        mot_done;
    logic        busy;
    logic        concluido;
    logic        fault;
    logic [1:0]  fault_code;
    logic [15:0] passos;

    int checks = 0;
    int errors = 0;
    int step_cnt = 0;
    int xfer_cnt = 0;
    logic [1:0] last_cmd = 2'b00;

    robo_sequenciador #(
        .DEB_CYC    (8),
        .TIMEOUT    (16),
        .MAX_GIROS  (4),
        .STEP_W     (16),
        .MAX_PASSOS (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .head_raw    (head_raw),
        .left_raw    (left_raw),
        .fsm_head    (fsm_head),
        .fsm_left    (fsm_left),
        .fsm_step    (fsm_step),
        .fsm_avancar (fsm_avancar),
        .fsm_girar   (fsm_girar),
        .mot_cmd     (mot_cmd),
        .mot_valid   (mot_valid),
        .mot_ready   (mot_ready),
        .mot_done    (mot_done),
        .busy        (busy),
        .concluido   (concluido),
        .fault       (fault),
        .fault_code  (fault_code),
        .passos      (passos)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (fsm_step) step_cnt++;
        if (mot_valid && mot_ready) begin
            xfer_cnt++;
            last_cmd = mot_cmd;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!mot_valid && n < 200) begin
            tick();
            n++;
        end
        check(tag, 32'(mot_valid), 1);
    endtask

    // One full handshake; done arrives in WAIT cycle done_at (1 = cycle right after transfer).
    task automatic do_move(input logic av, input logic gi, input int done_at, input string tag);
        fsm_avancar = av;
        fsm_girar   = gi;
        wait_valid(tag);
        mot_ready = 1'b1;
        tick();
        mot_ready = 1'b0;
        if (done_at > 1) tick(done_at - 1);
        mot_done = 1'b1;
        tick();
        mot_done = 1'b0;
    endtask

    initial begin
        int s0;
        int x0;
        int n;
        int held;
        logic final_head;

        reset = 1'b1; start = 1'b0; stop = 1'b0;
        head_raw = 1'b0; left_raw = 1'b1;
        fsm_avancar = 1'b0; fsm_girar = 1'b0;
        mot_ready = 1'b0; mot_done = 1'b0;
        tick(3);
        check("rst_busy", 32'(busy), 0);
        check("rst_flags", 32'({concluido, fault, fault_code}), 0);
        check("rst_mot", 32'({mot_valid, mot_cmd, fsm_step}), 0);
        check("rst_passos", 32'(passos), 0);
        check("rst_sensors", 32'({fsm_head, fsm_left}), 0);
        reset = 1'b0;
        tick();

        // 1: single forward move, done in the third WAIT cycle
        s0 = step_cnt; x0 = xfer_cnt;
        fsm_avancar = 1'b1;
        pulse_start();
        check("t1_busy", 32'(busy), 1);
        do_move(1'b1, 1'b0, 3, "t1_valid");
        check("t1_steps", 32'(step_cnt - s0), 1);
        check("t1_xfers", 32'(xfer_cnt - x0), 1);
        check("t1_cmd", 32'(last_cmd), 1);
        check("t1_sensors", 32'({fsm_head, fsm_left}), 1);
        check("t1_passos", 32'(passos), 1);
        check("t1_settle", 32'({busy, mot_valid, mot_cmd, fsm_step}), 32'b10000);

        // 2: ready held low 5 cycles -> valid/cmd held 6 cycles
        x0 = xfer_cnt;
        fsm_avancar = 1'b1;
        wait_valid("t2_valid");
        held = 0;
        for (int i = 0; i < 6; i++) begin
            if (mot_valid && mot_cmd == 2'b01) held++;
            if (i == 5) mot_ready = 1'b1;
            tick();
        end
        mot_ready = 1'b0;
        check("t2_held", 32'(held), 6);
        check("t2_xfers", 32'(xfer_cnt - x0), 1);
        check("t2_wait_out", 32'({mot_valid, mot_cmd}), 32'b001);
        mot_done = 1'b1;
        tick();
        mot_done = 1'b0;
        check("t2_passos", 32'(passos), 2);

        // 3: motor never finishes -> timeout after 16 WAIT cycles
        wait_valid("t3_valid");
        mot_ready = 1'b1;
        tick();
        mot_ready = 1'b0;
        held = 0; n = 0;
        while (!fault && n < 60) begin
            if (!mot_valid && mot_cmd == 2'b01) held++;
            tick();
            n++;
        end
        check("t3_wait_cycles", 32'(held), 16);
        check("t3_fault", 32'(fault), 1);
        check("t3_code", 32'(fault_code), 1);
        check("t3_cmd_busy", 32'({mot_cmd, busy}), 0);
        tick(4);
        check("t3_sticky", 32'({fault, fault_code, passos}), 32'({1'b1, 2'b01, 16'd2}));

        // 4: girar x3, avancar, girar x4 -> stuck only after the last rotation
        pulse_start();
        check("t4_cleared", 32'({fault, fault_code, passos}), 0);
        for (int i = 0; i < 3; i++) do_move(1'b0, 1'b1, 1, "t4_valid_g");
        do_move(1'b1, 1'b0, 1, "t4_valid_a");
        check("t4_passos", 32'(passos), 1);
        for (int i = 0; i < 3; i++) do_move(1'b0, 1'b1, 1, "t4_valid_g2");
        check("t4_no_fault_yet", 32'({fault, fault_code}), 0);
        do_move(1'b0, 1'b1, 2, "t4_valid_last");
        check("t4_fault", 32'({fault, fault_code}), 32'b110);
        check("t4_passos_end", 32'(passos), 1);
        check("t4_cmd", 32'(mot_cmd), 0);

        // 5a: stop in SETTLE, and start+stop together in IDLE
        s0 = step_cnt;
        pulse_start();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t5_stop_settle", 32'(busy), 0);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("t5_start_stop", 32'(busy), 0);
        check("t5_no_step", 32'(step_cnt - s0), 0);

        // 5b: stop latched in WAIT, completion still counted, then IDLE
        fsm_avancar = 1'b1; fsm_girar = 1'b0;
        pulse_start();
        wait_valid("t5_valid");
        mot_ready = 1'b1;
        tick();
        mot_ready = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        check("t5_still_wait", 32'({busy, mot_cmd}), 32'b101);
        mot_done = 1'b1;
        tick();
        mot_done = 1'b0;
        check("t5_idle", 32'({busy, fault, concluido}), 0);
        check("t5_passos", 32'(passos), 1);
        s0 = step_cnt;
        tick(20);
        check("t5_no_new_step", 32'(step_cnt - s0), 0);

        // 5c: both decision outputs high -> illegal command fault
        x0 = xfer_cnt;
        fsm_avancar = 1'b1; fsm_girar = 1'b1;
        pulse_start();
        n = 0;
        while (!fault && n < 100) begin
            tick();
            n++;
        end
        check("t5_illegal", 32'({fault, fault_code}), 32'b111);
        check("t5_no_xfer", 32'(xfer_cnt - x0), 0);

        // 7: MAX_PASSOS=3 forward moves -> DONE
        pulse_start();
        for (int i = 0; i < 3; i++) do_move(1'b1, 1'b0, 2, "t7_valid");
        check("t7_done", 32'({concluido, busy, fault}), 32'b100);
        check("t7_passos", 32'(passos), 3);
        s0 = step_cnt;
        tick(5);
        check("t7_sticky", 32'({concluido, mot_cmd}), 32'b100);
        check("t7_no_step", 32'(step_cnt - s0), 0);

        // 6: head toggling every 3 cycles blocks stepping; steady head steps DEB_CYC+2 later
        s0 = step_cnt;
        head_raw = ~head_raw;
        tick(3);
        head_raw = ~head_raw;
        tick();
        pulse_start();
        tick();
        for (int i = 0; i < 8; i++) begin
            head_raw = ~head_raw;
            tick(3);
        end
        check("t6_no_step", 32'(step_cnt - s0), 0);
        head_raw = ~head_raw;
        final_head = head_raw;
        n = 0;
        while (!fsm_step && n < 40) begin
            tick();
            n++;
        end
        check("t6_latency", 32'(n), 10);
        check("t6_head", 32'(fsm_head), 32'(final_head));
        check("t6_left", 32'(fsm_left), 1);

        // Reset while a command is outstanding
        wait_valid("rst_mid_valid");
        reset = 1'b1;
        tick();
        check("rst_mid_mot", 32'({mot_valid, mot_cmd, busy}), 0);
        check("rst_mid_regs", 32'({fsm_head, fsm_left, passos}), 0);
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
